// File: rtl/sink_apb_master.sv
// -----------------------------------------------------------------------------
// sink_apb_master
//   Pops request packets from a request FIFO, runs each one as a single APB
//   transfer (SETUP then ACCESS, with a bounded wait for PREADY), and pushes
//   one response packet per transfer into a response FIFO. Sleep requests are
//   honoured only between transfers.
//
// Ports
//   i_clk_sink, i_rstn_sink   clock, asynchronous active-low reset
//   i_req_packet, i_req_empty request FIFO head entry and empty flag
//   o_req_rd_en               request FIFO pop strobe
//   o_rsp_packet, o_rsp_wr_en response FIFO data and push strobe
//   i_rsp_full                response FIFO full flag
//   o_psel, o_penable, o_pwrite, o_paddr, o_pwdata   APB requester outputs
//   i_pready, i_pslverr, i_prdata                     APB completer response
//   i_sink_sleep_req, o_sink_sleep_ack                sleep handshake
//
// Request packet : {rd0_wr1, reserved, addr[A-1:0], wdata[D-1:0]}
// Response packet: {error, rdata[D-1:0]} (data is zero for writes)
// -----------------------------------------------------------------------------
module sink_apb_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                             i_clk_sink,
  input  logic                             i_rstn_sink,
  input  logic [ADDR_WIDTH+DATA_WIDTH+1:0] i_req_packet,
  input  logic                             i_req_empty,
  output logic                             o_req_rd_en,
  output logic [DATA_WIDTH:0]              o_rsp_packet,
  input  logic                             i_rsp_full,
  output logic                             o_rsp_wr_en,
  output logic                             o_psel,
  output logic                             o_penable,
  output logic                             o_pwrite,
  output logic [ADDR_WIDTH-1:0]            o_paddr,
  output logic [DATA_WIDTH-1:0]            o_pwdata,
  input  logic                             i_pready,
  input  logic                             i_pslverr,
  input  logic [DATA_WIDTH-1:0]            i_prdata,
  input  logic                             i_sink_sleep_req,
  output logic                             o_sink_sleep_ack
);

  // Counter is sized for the largest legal TIMEOUT (255).
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned WR_BIT   = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int unsigned RSV_BIT  = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned ADDR_LSB = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    req_rd_en_q, req_rd_en_d;
  logic                    rsp_wr_en_q, rsp_wr_en_d;
  logic [DATA_WIDTH:0]     rsp_packet_q, rsp_packet_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    sleep_ack_q, sleep_ack_d;

  logic [CNT_W-1:0]        cnt_inc;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    unused_rsv;

  // The reserved packet bit carries no meaning for this block.
  assign unused_rsv = i_req_packet[RSV_BIT];

  assign cnt_inc = cnt_q + CNT_W'(1);
  // Writes return zero data regardless of what the completer drives.
  assign rd_data = pwrite_q ? '0 : i_prdata;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_rd_en_d  = 1'b0;
    rsp_wr_en_d  = 1'b0;
    psel_d       = 1'b0;
    penable_d    = 1'b0;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_packet_d = rsp_packet_q;

    case (state_q)
      IDLE: begin
        // Latch the head entry and pop it in the same cycle SETUP is entered.
        if (!i_req_empty && !i_sink_sleep_req) begin
          state_d     = SETUP;
          req_rd_en_d = 1'b1;
          psel_d      = 1'b1;
          pwrite_d    = i_req_packet[WR_BIT];
          paddr_d     = i_req_packet[ADDR_LSB +: ADDR_WIDTH];
          pwdata_d    = i_req_packet[DATA_WIDTH-1:0];
          cnt_d       = '0;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ACCESS: begin
        if (i_pready) begin
          state_d      = RESP;
          rsp_packet_d = {i_pslverr, rd_data};
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          // Completer never answered: abort with an error response.
          state_d      = RESP;
          cnt_d        = cnt_inc;
          rsp_packet_d = {1'b1, {DATA_WIDTH{1'b0}}};
        end else begin
          cnt_d     = cnt_inc;
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end
      end

      RESP: begin
        if (!i_rsp_full) begin
          state_d     = IDLE;
          rsp_wr_en_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Acknowledge only when the FSM is (about to be) parked in IDLE.
    sleep_ack_d = (state_d == IDLE) && i_sink_sleep_req;
  end

  // State and output registers.
  always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
    if (!i_rstn_sink) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_rd_en_q  <= 1'b0;
      rsp_wr_en_q  <= 1'b0;
      rsp_packet_q <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      sleep_ack_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_rd_en_q  <= req_rd_en_d;
      rsp_wr_en_q  <= rsp_wr_en_d;
      rsp_packet_q <= rsp_packet_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      sleep_ack_q  <= sleep_ack_d;
    end
  end

  assign o_req_rd_en      = req_rd_en_q;
  assign o_rsp_wr_en      = rsp_wr_en_q;
  assign o_rsp_packet     = rsp_packet_q;
  assign o_psel           = psel_q;
  assign o_penable        = penable_q;
  assign o_pwrite         = pwrite_q;
  assign o_paddr          = paddr_q;
  assign o_pwdata         = pwdata_q;
  assign o_sink_sleep_ack = sleep_ack_q;

endmodule

// File: tb/tb_sink_apb_master.sv
// Self-checking bench for sink_apb_master: FIFO and APB completer models are
// driven at the falling edge; expected responses and push times come from a
// per-transfer descriptor (wait states, read data, error, backpressure).
module tb_sink_apb_master;

  localparam int A     = 32;
  localparam int D     = 32;
  localparam int TO    = 16;
  localparam int PKT_W = A + D + 2;
  localparam int RSP_W = D + 1;

  typedef struct {
    logic [PKT_W-1:0] pkt;
    int               wait_n;
    logic [D-1:0]     rdata;
    logic             err;
    int               bp_n;
  } desc_t;

  typedef struct {
    int               cyc;
    logic [RSP_W-1:0] exp_rsp;
    int               exp_push;
    logic             psel;
    logic             penable;
    logic             pwrite;
    logic [A-1:0]     paddr;
    logic [D-1:0]     pwdata;
  } pop_t;

  typedef struct {
    int               cyc;
    logic [RSP_W-1:0] rsp;
    logic             ack;
  } push_t;

  logic             clk, rst_n;
  logic [PKT_W-1:0] i_req_packet;
  logic             i_req_empty, o_req_rd_en;
  logic [RSP_W-1:0] o_rsp_packet;
  logic             i_rsp_full, o_rsp_wr_en;
  logic             o_psel, o_penable, o_pwrite;
  logic [A-1:0]     o_paddr;
  logic [D-1:0]     o_pwdata;
  logic             i_pready, i_pslverr;
  logic [D-1:0]     i_prdata;
  logic             i_sleep, o_ack;

  sink_apb_master #(.ADDR_WIDTH(A), .DATA_WIDTH(D), .TIMEOUT(TO)) dut (
    .i_clk_sink(clk), .i_rstn_sink(rst_n),
    .i_req_packet(i_req_packet), .i_req_empty(i_req_empty), .o_req_rd_en(o_req_rd_en),
    .o_rsp_packet(o_rsp_packet), .i_rsp_full(i_rsp_full), .o_rsp_wr_en(o_rsp_wr_en),
    .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
    .o_paddr(o_paddr), .o_pwdata(o_pwdata),
    .i_pready(i_pready), .i_pslverr(i_pslverr), .i_prdata(i_prdata),
    .i_sink_sleep_req(i_sleep), .o_sink_sleep_ack(o_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int viol_rd = 0, viol_wr = 0, apb_bad = 0, aborted = 0;
  int acc_cnt = 0, bp_cnt = 0, pen_run = 0;
  logic in_resp = 1'b0, prev_pen = 1'b0;
  logic last_wr = 1'b0;
  logic [A-1:0] last_addr = '0;
  logic [D-1:0] last_wd = '0;
  desc_t cur;
  desc_t desc_q[$];
  pop_t  pops[$];
  push_t pushes[$];
  int    pen_log[$];

  // Reference: what the response FIFO should receive for a transfer.
  function automatic logic [RSP_W-1:0] ref_rsp(desc_t d);
    if (d.wait_n >= TO) return {1'b1, D'(0)};
    return {d.err, d.pkt[PKT_W-1] ? D'(0) : d.rdata};
  endfunction

  // Reference: cycles from pop strobe to push strobe.
  function automatic int ref_lat(desc_t d);
    int w;
    w = (d.wait_n >= TO) ? TO - 1 : d.wait_n;
    return 3 + w + d.bp_n;
  endfunction

  function automatic desc_t mk_desc(logic wr, logic [A-1:0] addr, logic [D-1:0] wd,
                                    int wait_n, logic [D-1:0] rdata, logic err, int bp_n);
    desc_t d;
    d.pkt = {wr, 1'($urandom), addr, wd};
    d.wait_n = wait_n; d.rdata = rdata; d.err = err; d.bp_n = bp_n;
    return d;
  endfunction

  function automatic desc_t rand_desc(int max_bp);
    int w;
    w = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 40) : $urandom_range(0, 4);
    return mk_desc(1'($urandom), $urandom, $urandom, w, $urandom, 1'($urandom),
                   $urandom_range(0, max_bp));
  endfunction

  task automatic refresh_req();
    i_req_empty = (desc_q.size() == 0);
    if (i_req_empty) i_req_packet = PKT_W'({$urandom, $urandom, $urandom});
    else             i_req_packet = desc_q[0].pkt;
  endtask

  task automatic add(desc_t d);
    desc_q.push_back(d);
    refresh_req();
  endtask

  // One clock: observe at the falling edge, then drive FIFO flags and completer.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (o_req_rd_en) begin
      if (i_req_empty || desc_q.size() == 0) viol_rd++;
      else begin
        pop_t p;
        cur = desc_q.pop_front();
        p.cyc = cyc; p.exp_rsp = ref_rsp(cur); p.exp_push = cyc + ref_lat(cur);
        p.psel = o_psel; p.penable = o_penable; p.pwrite = o_pwrite;
        p.paddr = o_paddr; p.pwdata = o_pwdata;
        pops.push_back(p);
        last_wr = cur.pkt[PKT_W-1]; last_addr = cur.pkt[D +: A]; last_wd = cur.pkt[D-1:0];
      end
    end
    if (o_rsp_wr_en) begin
      push_t s;
      if (i_rsp_full) viol_wr++;
      s.cyc = cyc; s.rsp = o_rsp_packet; s.ack = o_ack;
      pushes.push_back(s);
    end
    if ({o_pwrite, o_paddr, o_pwdata} !== {last_wr, last_addr, last_wd}) apb_bad++;
    if (o_penable && !o_psel) apb_bad++;
    if (o_psel && !o_penable) pen_run = 0;
    if (o_penable) pen_run++;
    if (prev_pen && !o_penable) pen_log.push_back(pen_run);
    i_prdata = $urandom; i_pslverr = 1'($urandom); i_pready = 1'($urandom);
    if (o_psel && o_penable) begin
      if (acc_cnt == cur.wait_n) begin
        i_pready = 1'b1; i_prdata = cur.rdata; i_pslverr = cur.err;
      end else i_pready = 1'b0;
      acc_cnt++;
    end else acc_cnt = 0;
    if (prev_pen && !o_psel && rst_n) begin in_resp = 1'b1; bp_cnt = 0; end
    i_rsp_full = 1'b0;
    if (in_resp) begin
      if (bp_cnt < cur.bp_n) begin i_rsp_full = 1'b1; bp_cnt++; end
      else in_resp = 1'b0;
    end
    prev_pen = o_penable;
    refresh_req();
  endtask

  task automatic run_until_idle(int budget, string name);
    int n = 0;
    while (!(desc_q.size() == 0 && pushes.size() + aborted == pops.size()) && n < budget) begin
      tick(); n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_err++;
      $display("FAIL %s_drain: pending=%0d pops=%0d pushes=%0d", name, desc_q.size(), pops.size(), pushes.size());
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_sleep = 1'b0; i_rsp_full = 1'b0; i_pready = 1'b0;
    i_pslverr = 1'b0; i_prdata = '0;
    cur = mk_desc(1'b0, '0, '0, 0, '0, 1'b0, 0);
    refresh_req();
    repeat (3) tick();
    n_cmp++;
    if ({o_req_rd_en, o_rsp_wr_en, o_psel, o_penable, o_pwrite, o_ack, o_paddr, o_pwdata, o_rsp_packet} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got nonzero outputs, want all zero");
    end
    rst_n = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if ({o_req_rd_en, o_rsp_wr_en, o_psel, o_penable, o_ack} !== '0) begin
      n_err++; $display("FAIL idle_after_reset: got ctrl=%b want 00000",
                        {o_req_rd_en, o_rsp_wr_en, o_psel, o_penable, o_ack});
    end
  endtask

  task automatic test_write();
    int p0 = pops.size(), s0 = pushes.size(), l0 = pen_log.size();
    add(mk_desc(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, $urandom, 1'b0, 0));
    run_until_idle(50, "write");
    n_cmp++;
    if (pops.size() != p0 + 1 || pushes.size() != s0 + 1 || pen_log.size() <= l0) begin
      n_err++; $display("FAIL write_count: pops=%0d pushes=%0d want 1/1", pops.size() - p0, pushes.size() - s0);
    end else begin
      n_cmp++;
      if ({pops[p0].psel, pops[p0].penable, pops[p0].pwrite, pops[p0].paddr, pops[p0].pwdata}
          !== {1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF}) begin
        n_err++; $display("FAIL write_setup: got psel=%b pen=%b pwr=%b addr=%h wd=%h want 1 0 1 00001000 deadbeef",
                          pops[p0].psel, pops[p0].penable, pops[p0].pwrite, pops[p0].paddr, pops[p0].pwdata);
      end
      n_cmp++;
      if (pushes[s0].rsp !== 33'h0_0000_0000) begin
        n_err++; $display("FAIL write_rsp: got %h want 000000000", pushes[s0].rsp);
      end
      n_cmp++;
      if (pushes[s0].cyc - pops[p0].cyc != 3) begin
        n_err++; $display("FAIL write_latency: got %0d want 3", pushes[s0].cyc - pops[p0].cyc);
      end
      n_cmp++;
      if (pen_log[pen_log.size()-1] != 1) begin
        n_err++; $display("FAIL write_penable: got %0d cycles want 1", pen_log[pen_log.size()-1]);
      end
    end
  endtask

  // Shared body for single read transfers with a chosen completer behaviour.
  task automatic test_read(string name, int wait_n, logic err, logic [D-1:0] rdata,
                           logic [RSP_W-1:0] want_rsp, int want_pen, int want_lat);
    int p0 = pops.size(), s0 = pushes.size(), l0 = pen_log.size();
    logic [A-1:0] addr = $urandom;
    add(mk_desc(1'b0, addr, $urandom, wait_n, rdata, err, 0));
    run_until_idle(100, name);
    n_cmp++;
    if (pops.size() != p0 + 1 || pushes.size() != s0 + 1 || pen_log.size() <= l0) begin
      n_err++; $display("FAIL %s_count: pops=%0d pushes=%0d want 1/1", name, pops.size() - p0, pushes.size() - s0);
    end else begin
      n_cmp++;
      if ({pops[p0].pwrite, pops[p0].paddr} !== {1'b0, addr}) begin
        n_err++; $display("FAIL %s_setup: got pwr=%b addr=%h want 0 %h", name, pops[p0].pwrite, pops[p0].paddr, addr);
      end
      n_cmp++;
      if (pushes[s0].rsp !== want_rsp) begin
        n_err++; $display("FAIL %s_rsp: got %h want %h", name, pushes[s0].rsp, want_rsp);
      end
      n_cmp++;
      if (pen_log[pen_log.size()-1] != want_pen) begin
        n_err++; $display("FAIL %s_penable: got %0d want %0d", name, pen_log[pen_log.size()-1], want_pen);
      end
      n_cmp++;
      if (pushes[s0].cyc - pops[p0].cyc != want_lat) begin
        n_err++; $display("FAIL %s_latency: got %0d want %0d", name, pushes[s0].cyc - pops[p0].cyc, want_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int p0 = pops.size(), s0 = pushes.size(), n = 0;
    desc_t d1, d2;
    d1 = mk_desc(1'b0, $urandom, $urandom, 1, $urandom, 1'b0, 5);
    d2 = mk_desc(1'b1, $urandom, $urandom, 0, $urandom, 1'b1, 0);
    add(d1); add(d2);
    while (!in_resp && n < 20) begin tick(); n++; end
    n_cmp++;
    if (!in_resp) begin
      n_err++; $display("FAIL bp_reach_resp: response phase not seen within 20 cycles");
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (i > 0) tick();
        n_cmp++;
        if (o_rsp_wr_en !== 1'b0 || o_rsp_packet !== ref_rsp(d1) || pops.size() != p0 + 1) begin
          n_err++; $display("FAIL bp_stall%0d: got wr=%b pkt=%h pops=%0d want 0 %h %0d",
                            i, o_rsp_wr_en, o_rsp_packet, pops.size() - p0, ref_rsp(d1), 1);
        end
      end
      tick();
      n_cmp++;
      if (o_rsp_wr_en !== 1'b1) begin
        n_err++; $display("FAIL bp_push: got wr_en=%b want 1", o_rsp_wr_en);
      end
      tick();
      n_cmp++;
      if ({o_rsp_wr_en, o_req_rd_en} !== 2'b01) begin
        n_err++; $display("FAIL bp_next_pop: got wr,rd=%b want 01", {o_rsp_wr_en, o_req_rd_en});
      end
    end
    run_until_idle(60, "bp");
    n_cmp++;
    if (pushes.size() != s0 + 2 || pushes[pushes.size()-1].rsp !== ref_rsp(d2)) begin
      n_err++; $display("FAIL bp_second: pushes=%0d want 2, last rsp=%h want %h",
                        pushes.size() - s0, pushes[pushes.size()-1].rsp, ref_rsp(d2));
    end
  endtask

  task automatic test_sleep();
    int p0 = pops.size(), s0 = pushes.size(), n = 0;
    desc_t d;
    d = mk_desc(1'b0, $urandom, $urandom, 2, $urandom, 1'b0, 0);
    add(d);
    for (int i = 0; i < 2; i++) add(rand_desc(1));
    while (!o_penable && n < 20) begin tick(); n++; end
    i_sleep = 1'b1;
    n = 0;
    while (pushes.size() < s0 + 1 && n < 40) begin tick(); n++; end
    n_cmp++;
    if (pushes.size() < s0 + 1) begin
      n_err++; $display("FAIL sleep_complete: no push within 40 cycles");
    end else begin
      n_cmp++;
      if ({pushes[s0].ack, pushes[s0].rsp} !== {1'b1, ref_rsp(d)}) begin
        n_err++; $display("FAIL sleep_push: got ack=%b rsp=%h want 1 %h", pushes[s0].ack, pushes[s0].rsp, ref_rsp(d));
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (o_ack !== 1'b1 || o_psel !== 1'b0 || pops.size() != p0 + 1) begin
        n_err++; $display("FAIL sleep_hold%0d: got ack=%b psel=%b pops=%0d want 1 0 1", i, o_ack, o_psel, pops.size() - p0);
      end
    end
    i_sleep = 1'b0;
    tick();
    n_cmp++;
    if ({o_ack, o_req_rd_en} !== 2'b01) begin
      n_err++; $display("FAIL sleep_release: got ack,rd=%b want 01", {o_ack, o_req_rd_en});
    end
    run_until_idle(200, "sleep");
    n_cmp++;
    if (pushes.size() != s0 + 3) begin
      n_err++; $display("FAIL sleep_total: got %0d pushes want 3", pushes.size() - s0);
    end
  endtask

  task automatic test_reset_mid();
    int s0, p1, n = 0;
    desc_t d;
    s0 = pushes.size();
    add(mk_desc(1'b1, $urandom, $urandom, 1000, $urandom, 1'b0, 0));
    while (!o_penable && n < 20) begin tick(); n++; end
    repeat (2) tick();
    rst_n = 1'b0;
    last_wr = 1'b0; last_addr = '0; last_wd = '0;
    aborted++;
    #1;
    n_cmp++;
    if ({o_req_rd_en, o_rsp_wr_en, o_psel, o_penable, o_pwrite, o_ack, o_paddr, o_pwdata, o_rsp_packet} !== '0) begin
      n_err++; $display("FAIL reset_mid_async: outputs nonzero while reset asserted, psel=%b pen=%b", o_psel, o_penable);
    end
    repeat (2) tick();
    in_resp = 1'b0; prev_pen = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (pushes.size() != s0) begin
      n_err++; $display("FAIL reset_mid_nopush: got %0d pushes want 0", pushes.size() - s0);
    end
    p1 = pops.size();
    d = rand_desc(2);
    add(d);
    run_until_idle(100, "after_reset");
    n_cmp++;
    if (pushes.size() != s0 + 1 || pushes[pushes.size()-1].rsp !== ref_rsp(d)
        || pushes[pushes.size()-1].cyc != pops[p1].exp_push) begin
      n_err++; $display("FAIL after_reset_xfer: pushes=%0d rsp=%h want 1 %h", pushes.size() - s0,
                        pushes[pushes.size()-1].rsp, ref_rsp(d));
    end
  endtask

  task automatic test_back_to_back();
    int p0 = pops.size(), s0 = pushes.size();
    for (int i = 0; i < 6; i++) add(mk_desc(1'($urandom), $urandom, $urandom,
                                          $urandom_range(0, 3), $urandom, 1'($urandom), 0));
    run_until_idle(200, "b2b");
    n_cmp++;
    if (pops.size() != p0 + 6 || pushes.size() != s0 + 6) begin
      n_err++; $display("FAIL b2b_count: pops=%0d pushes=%0d want 6/6", pops.size() - p0, pushes.size() - s0);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (pushes[s0+i].rsp !== pops[p0+i].exp_rsp || pushes[s0+i].cyc != pops[p0+i].exp_push) begin
          n_err++; $display("FAIL b2b_xfer%0d: got rsp=%h cyc=%0d want %h %0d", i, pushes[s0+i].rsp,
                            pushes[s0+i].cyc, pops[p0+i].exp_rsp, pops[p0+i].exp_push);
        end
        if (i > 0) begin
          n_cmp++;
          if (pops[p0+i].cyc != pushes[s0+i-1].cyc + 1) begin
            n_err++; $display("FAIL b2b_gap%0d: pop at %0d want %0d", i, pops[p0+i].cyc, pushes[s0+i-1].cyc + 1);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int p0 = pops.size(), s0 = pushes.size(), added = 0;
    while (added < 40) begin
      if ($urandom_range(0, 2) != 0) begin add(rand_desc(3)); added++; end
      repeat ($urandom_range(0, 4)) tick();
    end
    run_until_idle(3000, "random");
    n_cmp++;
    if (pops.size() != p0 + 40 || pushes.size() != s0 + 40) begin
      n_err++; $display("FAIL random_count: pops=%0d pushes=%0d want 40/40", pops.size() - p0, pushes.size() - s0);
    end else begin
      for (int i = 0; i < 40; i++) begin
        n_cmp++;
        if (pushes[s0+i].rsp !== pops[p0+i].exp_rsp || pushes[s0+i].cyc != pops[p0+i].exp_push) begin
          n_err++; $display("FAIL random_xfer%0d: got rsp=%h cyc=%0d want %h %0d", i, pushes[s0+i].rsp,
                            pushes[s0+i].cyc, pops[p0+i].exp_rsp, pops[p0+i].exp_push);
        end
      end
    end
  endtask

  task automatic test_invariants();
    n_cmp++;
    if (viol_rd != 0) begin n_err++; $display("FAIL pop_when_empty: got %0d want 0", viol_rd); end
    n_cmp++;
    if (viol_wr != 0) begin n_err++; $display("FAIL push_when_full: got %0d want 0", viol_wr); end
    n_cmp++;
    if (apb_bad != 0) begin n_err++; $display("FAIL apb_hold: got %0d bad cycles want 0", apb_bad); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read("read_wait3", 3, 1'b0, 32'h1234_5678, 33'h0_1234_5678, 4, 6);
    test_read("timeout", 1000, 1'b0, 32'h5555_AAAA, 33'h1_0000_0000, TO, TO + 2);
    test_read("last_chance", TO - 1, 1'b1, 32'hCAFE_F00D, 33'h1_CAFE_F00D, TO, TO + 2);
    test_backpressure();
    test_sleep();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
